// File: rtl/render_sequencer.sv
// Frame-level render controller: walks the enabled draw engines in priority order and
// multiplexes the active engine onto the single DDR burst master port.
module render_sequencer #(
    parameter int NUM_LAYERS     = 4,
    parameter int COLOR_W        = 12,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int IDX_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int WD_W          = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic                          clk100,
    input  logic                          resetn,
    input  logic                          draw,
    input  logic                          abort,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    output logic                          draw_done,
    output logic                          timeout_err,
    output logic                          busy,
    output logic [IDX_W-1:0]              active_layer,
    output logic [15:0]                   frame_count,
    output logic [NUM_LAYERS-1:0]         layer_draw,
    input  logic [NUM_LAYERS-1:0]         layer_done,
    input  logic [NUM_LAYERS-1:0]         layer_txn_init,
    input  logic [NUM_LAYERS*32-1:0]      layer_offset_addr,
    input  logic [NUM_LAYERS*32-1:0]      layer_pixel_count,
    output logic [NUM_LAYERS-1:0]         layer_txn_done,
    output logic                          TXN_INIT,
    input  logic                          TXN_DONE,
    output logic [31:0]                   offset_addr,
    output logic [COLOR_W-1:0]            color,
    output logic [31:0]                   pixel_count
);

    typedef enum logic [1:0] {IDLE, SELECT, DRAW, DONE} state_t;

    state_t                state, state_nxt;
    logic                  ff1, ff2;
    logic                  draw_pulse;
    logic [NUM_LAYERS-1:0] pending, pending_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [WD_W-1:0]       watchdog, watchdog_nxt;
    logic                  timeout_flag, timeout_flag_nxt;
    logic                  wd_expired;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_LAYERS-1:0] mask);
        lowest_set = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    assign draw_pulse = ff1 & ~ff2;
    assign wd_expired = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state        <= IDLE;
            ff1          <= 1'b0;
            ff2          <= 1'b0;
            pending      <= '0;
            idx          <= '0;
            watchdog     <= '0;
            timeout_flag <= 1'b0;
            frame_count  <= 16'd0;
        end else begin
            state        <= state_nxt;
            ff1          <= draw;
            ff2          <= ff1;
            pending      <= pending_nxt;
            idx          <= idx_nxt;
            watchdog     <= watchdog_nxt;
            timeout_flag <= timeout_flag_nxt;
            // An abort that lands on the DONE cycle discards the frame.
            if (state == DONE && !timeout_flag && !abort)
                frame_count <= frame_count + 16'd1;
        end
    end

    always_comb begin
        state_nxt        = state;
        pending_nxt      = pending;
        idx_nxt          = idx;
        watchdog_nxt     = watchdog;
        timeout_flag_nxt = timeout_flag;
        if (abort) begin
            state_nxt        = IDLE;
            pending_nxt      = '0;
            watchdog_nxt     = '0;
            timeout_flag_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (draw_pulse) begin
                        pending_nxt      = layer_en;
                        timeout_flag_nxt = 1'b0;
                        state_nxt        = SELECT;
                    end
                end
                SELECT: begin
                    if (pending == '0) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt      = lowest_set(pending);
                        watchdog_nxt = '0;
                        state_nxt    = DRAW;
                    end
                end
                DRAW: begin
                    // Expiry outranks a same-cycle layer_done.
                    if (wd_expired) begin
                        pending_nxt      = '0;
                        timeout_flag_nxt = 1'b1;
                        state_nxt        = DONE;
                    end else if (layer_done[idx]) begin
                        pending_nxt[idx] = 1'b0;
                        state_nxt        = SELECT;
                    end else if (TXN_DONE) begin
                        watchdog_nxt = '0;
                    end else begin
                        watchdog_nxt = watchdog + WD_W'(1);
                    end
                end
                DONE: begin
                    timeout_flag_nxt = 1'b0;
                    state_nxt        = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign draw_done   = (state == DONE);
    assign timeout_err = (state == DONE) & timeout_flag;

    always_comb begin
        layer_draw     = '0;
        layer_txn_done = '0;
        active_layer   = '0;
        TXN_INIT       = 1'b0;
        offset_addr    = '0;
        color          = '0;
        pixel_count    = '0;
        if (state == DRAW) begin
            layer_draw[idx]     = 1'b1;
            layer_txn_done[idx] = TXN_DONE;
            active_layer        = idx;
            TXN_INIT            = layer_txn_init[idx];
            offset_addr         = layer_offset_addr[int'(idx)*32 +: 32];
            color               = layer_color[int'(idx)*COLOR_W +: COLOR_W];
            pixel_count         = layer_pixel_count[int'(idx)*32 +: 32];
        end
    end

endmodule

// File: tb/tb_render_sequencer.sv
// Bench for render_sequencer: directed frame scenarios plus random traffic, all checked
// every cycle against a queue-based frame model.
module tb_render_sequencer;

    localparam int NL = 4;
    localparam int CW = 12;
    localparam int TO = 16;

    logic           clk100 = 1'b0;
    logic           resetn, draw, abort, TXN_DONE;
    logic [NL-1:0]  layer_en, layer_done, layer_txn_init;
    logic [NL*CW-1:0] layer_color;
    logic [NL*32-1:0] layer_offset_addr, layer_pixel_count;
    logic           draw_done, timeout_err, busy, TXN_INIT;
    logic [1:0]     active_layer;
    logic [15:0]    frame_count;
    logic [NL-1:0]  layer_draw, layer_txn_done;
    logic [31:0]    offset_addr, pixel_count;
    logic [CW-1:0]  color;

    render_sequencer #(.NUM_LAYERS(NL), .COLOR_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk100(clk100), .resetn(resetn), .draw(draw), .abort(abort),
        .layer_en(layer_en), .layer_color(layer_color),
        .draw_done(draw_done), .timeout_err(timeout_err), .busy(busy),
        .active_layer(active_layer), .frame_count(frame_count),
        .layer_draw(layer_draw), .layer_done(layer_done),
        .layer_txn_init(layer_txn_init), .layer_offset_addr(layer_offset_addr),
        .layer_pixel_count(layer_pixel_count), .layer_txn_done(layer_txn_done),
        .TXN_INIT(TXN_INIT), .TXN_DONE(TXN_DONE), .offset_addr(offset_addr),
        .color(color), .pixel_count(pixel_count)
    );

    always #5 clk100 = ~clk100;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on = 0;

    function automatic void check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Frame model: a queue of layers still to draw, the layer being drawn (-1 if none),
    // and the cycles spent in it since its last TXN_DONE.
    int          m_q[$];
    int          m_cur = -1;
    int          m_age = 0;
    bit          m_busy = 0, m_fin = 0, m_to = 0, m_d1 = 0, m_d2 = 0;
    logic [15:0] m_fc = 16'd0;

    always @(posedge clk100) begin
        bit start;
        if (!resetn) begin
            m_q.delete(); m_cur = -1; m_age = 0;
            m_busy = 0; m_fin = 0; m_to = 0; m_d1 = 0; m_d2 = 0; m_fc = 16'd0;
        end else begin
            start = m_d1 && !m_d2;
            m_d2 = m_d1;
            m_d1 = draw;
            if (abort) begin
                m_q.delete(); m_cur = -1; m_busy = 0; m_fin = 0; m_to = 0;
            end else if (m_fin) begin
                if (!m_to) m_fc = m_fc + 16'd1;
                m_fin = 0; m_to = 0; m_busy = 0;
            end else if (m_cur >= 0) begin
                if (m_age == TO - 1) begin
                    m_q.delete(); m_cur = -1; m_to = 1; m_fin = 1;
                end else if (layer_done[m_cur]) begin
                    m_cur = -1;
                end else begin
                    m_age = TXN_DONE ? 0 : m_age + 1;
                end
            end else if (m_busy) begin
                if (m_q.size() == 0) m_fin = 1;
                else begin m_cur = m_q.pop_front(); m_age = 0; end
            end else if (start) begin
                for (int i = 0; i < NL; i++) if (layer_en[i]) m_q.push_back(i);
                m_busy = 1;
            end
        end
    end

    // Observation counters for the directed scenarios.
    int n_done, n_to, n_routed, order_code;
    int lyr_cycles[NL];
    logic [NL-1:0] prev_ld = '0;

    always @(negedge clk100) begin
        logic [NL-1:0] e_ld, e_td;
        logic          e_init;
        logic [75:0]   e_bus;
        logic [1:0]    e_al;
        if (chk_on) begin
            e_ld = '0; e_td = '0; e_init = 1'b0; e_bus = '0; e_al = '0;
            if (m_cur >= 0) begin
                e_ld   = NL'(1 << m_cur);
                e_td   = TXN_DONE ? e_ld : '0;
                e_init = layer_txn_init[m_cur];
                e_bus  = {layer_offset_addr[m_cur*32 +: 32], layer_color[m_cur*CW +: CW],
                          layer_pixel_count[m_cur*32 +: 32]};
                e_al   = 2'(m_cur);
            end
            check("busy", busy, m_busy);
            check("draw_done", draw_done, m_fin);
            check("timeout_err", timeout_err, m_fin & m_to);
            check("frame_count", frame_count, m_fc);
            check("active_layer", active_layer, e_al);
            check("layer_draw", layer_draw, e_ld);
            check("layer_txn_done", layer_txn_done, e_td);
            check("TXN_INIT", TXN_INIT, e_init);
            check("master_bus", {offset_addr, color, pixel_count}, e_bus);
            n_done   += int'(draw_done);
            n_to     += int'(timeout_err);
            n_routed += int'(layer_txn_done != '0);
            if (layer_draw != '0) lyr_cycles[active_layer]++;
            if (layer_draw != '0 && prev_ld == '0) order_code = order_code * 16 + int'(active_layer);
            prev_ld = layer_draw;
        end
    end

    int bursts[NL];
    bit tick = 0;

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    task automatic idle_inputs();
        layer_done = '0; TXN_DONE = 1'b0; layer_txn_init = '0; abort = 1'b0;
    endtask

    task automatic reset_mon();
        n_done = 0; n_to = 0; n_routed = 0; order_code = 0;
        for (int i = 0; i < NL; i++) begin lyr_cycles[i] = 0; bursts[i] = 0; end
    endtask

    // Engine stand-in: two bursts per layer, TXN_DONE every other cycle, then layer_done.
    task automatic drive_engines(input int skip);
        int i;
        layer_done = '0; TXN_DONE = 1'b0; layer_txn_init = '0;
        if (layer_draw != '0) begin
            i = int'(active_layer);
            if (bursts[i] < 2) begin
                tick = ~tick;
                layer_txn_init[i] = tick;
                if (tick && i != skip) begin TXN_DONE = 1'b1; bursts[i]++; end
            end else begin
                layer_done[i] = 1'b1;
            end
        end
    endtask

    task automatic run_frame(input int skip, input logic [NL-1:0] mid_en, output int cyc);
        for (int i = 0; i < NL; i++) bursts[i] = 0;
        draw = 1'b1;
        cyc = 0;
        for (int n = 1; n <= 300; n++) begin
            step();
            drive_engines(skip);
            if (n == 3) layer_en = mid_en;
            if (draw_done) begin cyc = n; break; end
        end
        check("frame_end_reached", cyc != 0, 1);
        step();
        idle_inputs();
    endtask

    task automatic draw_low();
        draw = 1'b0;
        step(); step();
    endtask

    initial begin
        int cyc;
        bit hit;
        bit stall;
        resetn = 1'b0; draw = 1'b0; layer_en = '0;
        idle_inputs();
        for (int i = 0; i < NL; i++) begin
            layer_color[i*CW +: CW]        = CW'($urandom);
            layer_offset_addr[i*32 +: 32]  = $urandom;
            layer_pixel_count[i*32 +: 32]  = $urandom;
        end
        step();
        chk_on = 1;
        step();
        check("reset_outputs", {busy, draw_done, timeout_err, active_layer, frame_count, layer_draw,
              layer_txn_done, TXN_INIT, offset_addr, color, pixel_count}, '0);
        resetn = 1'b1;
        step();

        // Full frame: all four layers, two bursts each.
        reset_mon(); layer_en = 4'b1111;
        run_frame(-1, 4'b1111, cyc);
        check("full_order", order_code, 'h0123);
        check("full_routed", n_routed, 8);
        check("full_done", n_done, 1);
        check("full_fc", frame_count, 1);
        draw_low();

        // Masked frame with mid-frame enable change, then an empty mask.
        reset_mon(); layer_en = 4'b1010;
        run_frame(-1, 4'b1111, cyc);
        check("mask_order", order_code, 'h13);
        check("mask_fc", frame_count, 2);
        draw_low();
        reset_mon(); layer_en = 4'b0000;
        run_frame(-1, 4'b0000, cyc);
        check("empty_latency", cyc, 3);
        check("empty_fc", frame_count, 3);
        draw_low();

        // Watchdog: engine 2 never sees TXN_DONE.
        reset_mon(); layer_en = 4'b1111;
        run_frame(2, 4'b1111, cyc);
        check("wd_order", order_code, 'h012);
        check("wd_layer2_cycles", lyr_cycles[2], TO);
        check("wd_timeout_pulses", n_to, 1);
        check("wd_done_pulses", n_done, 1);
        check("wd_fc", frame_count, 3);
        draw_low();

        // Abort during layer 1, late TXN_DONE, then a normal frame.
        reset_mon(); layer_en = 4'b1111; draw = 1'b1; hit = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            drive_engines(-1);
            if (layer_draw[1] && bursts[1] == 1) begin abort = 1'b1; hit = 1; break; end
        end
        check("abort_reached", hit, 1);
        step();
        idle_inputs();
        check("abort_idle", {busy, layer_draw, TXN_INIT}, '0);
        TXN_DONE = 1'b1; layer_txn_init = '1;
        #1;
        check("abort_late_txn", {layer_txn_done, TXN_INIT}, '0);
        step();
        idle_inputs();
        draw_low();
        step();
        check("abort_no_done", n_done, 0);
        check("abort_fc", frame_count, 3);
        reset_mon();
        run_frame(-1, 4'b1111, cyc);
        check("post_abort_fc", frame_count, 4);
        draw_low();

        // Re-trigger while busy, then draw held high after the frame.
        reset_mon(); layer_en = 4'b1111; draw = 1'b1; cyc = 0;
        for (int n = 1; n <= 300; n++) begin
            step();
            drive_engines(-1);
            draw = (n >= 5 && n < 19) ? n[1] : 1'b1;
            if (draw_done) begin cyc = n; break; end
        end
        check("retrig_frame_end", cyc != 0, 1);
        for (int n = 0; n < 40; n++) begin step(); drive_engines(-1); end
        idle_inputs();
        check("retrig_done_count", n_done, 1);
        check("retrig_fc", frame_count, 5);
        draw_low();

        // Reset in the middle of DRAW.
        reset_mon(); layer_en = 4'b1111; draw = 1'b1; hit = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            drive_engines(-1);
            if (layer_draw[1]) begin hit = 1; break; end
        end
        check("rst_reached", hit, 1);
        resetn = 1'b0;
        step();
        idle_inputs();
        check("mid_reset_outputs", {busy, draw_done, timeout_err, active_layer, frame_count, layer_draw,
              layer_txn_done, TXN_INIT, offset_addr, color, pixel_count}, '0);
        resetn = 1'b1; draw = 1'b0;
        step(); step();

        // frame_count wrap from a preloaded 0xFFFF.
        force dut.frame_count = 16'hFFFF;
        m_fc = 16'hFFFF;
        step();
        release dut.frame_count;
        check("fc_preload", frame_count, 16'hFFFF);
        reset_mon(); layer_en = 4'b0001;
        run_frame(-1, 4'b0001, cyc);
        check("fc_wrap", frame_count, 16'h0000);
        draw_low();

        // Random traffic, alternating busy-bus and stalled-bus phases.
        stall = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 400 == 0) stall = ~stall;
            if ($urandom_range(0, 19) == 0) draw = ~draw;
            abort          = ($urandom_range(0, 149) == 0);
            resetn         = ($urandom_range(0, 999) != 0);
            layer_en       = NL'($urandom);
            layer_txn_init = NL'($urandom);
            TXN_DONE       = stall ? 1'b0 : ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NL; i++)
                layer_done[i] = stall ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
            if (n % 50 == 0) begin
                for (int i = 0; i < NL; i++) begin
                    layer_color[i*CW +: CW]       = CW'($urandom);
                    layer_offset_addr[i*32 +: 32] = $urandom;
                    layer_pixel_count[i*32 +: 32] = $urandom;
                end
            end
            step();
        end
        resetn = 1'b1;
        idle_inputs();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/render_sequencer.md
# render_sequencer

Parametrised top-level render controller that runs up to NUM_LAYERS draw engines (background, block, cursor, hexagon, …) in fixed priority order for each frame. It sits between the MicroBlaze-facing AXI slave registers and the DDR burst master. It multiplexes the active engine's transaction request onto the single master port, and adds the following:
- a per-frame layer-enable mask
- a per-layer colour
- a TXN_DONE steered only to the active engine
- a software abort
- a transaction watchdog
- a frame counter

## Interface
Parameters:
- NUM_LAYERS, 4, number of draw engines; layer 0 is drawn first.
- COLOR_W, 12, colour width per layer.
- TIMEOUT_CYCLES, 1000000, maximum cycles in one layer without a TXN_DONE before the frame is abandoned (minimum 2).

Ports:
- clk100  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- draw  in  1  frame request, level; rising edge starts a frame.
- abort  in  1  level; synchronous frame abort.
- layer_en  in  NUM_LAYERS  per-layer enable, sampled at frame start.
- layer_color  in  NUM_LAYERS*COLOR_W  colour of layer i at bits [i*COLOR_W +: COLOR_W].
- draw_done  out  1  one-cycle pulse at frame end (normal or timeout).
- timeout_err  out  1  one-cycle pulse, coincident with draw_done, on watchdog expiry.
- busy  out  1  high from frame start until draw_done or abort.
- active_layer  out  $clog2(NUM_LAYERS) (min 1)  index of the layer in DRAW; 0 otherwise.
- frame_count  out  16  completed (non-timeout) frames; wraps 0xFFFF→0.
- layer_draw  out  NUM_LAYERS  one-hot level start to engines.
- layer_done  in  NUM_LAYERS  per-engine done pulses.
- layer_txn_init  in  NUM_LAYERS  per-engine TXN_INIT.
- layer_offset_addr  in  NUM_LAYERS*32  per-engine address.
- layer_pixel_count  in  NUM_LAYERS*32  per-engine burst pixel count.
- layer_txn_done  out  NUM_LAYERS  TXN_DONE routed to the active engine only.
- TXN_INIT  out  1  to DDR master (edge-sensitive at master).
- TXN_DONE  in  1  one-cycle pulse from master.
- offset_addr  out  32, color  out  COLOR_W, pixel_count  out  32  to DDR master.

## Operation
- Draw edge detect:
  - draw → ff1 → ff2 registers.
  - draw_pulse = ff1 & ~ff2.
  - draw_pulse is ignored unless the state is IDLE; requests are not queued.
- States: IDLE, SELECT, DRAW, DONE.
  - IDLE: on draw_pulse, pending ← layer_en, busy ← 1, → SELECT.
  - SELECT:
    - If pending == 0 → DONE.
    - Otherwise idx ← lowest set bit of pending, watchdog ← 0, → DRAW.
  - DRAW:
    - layer_draw[idx] = 1.
    - On layer_done[idx], clear pending[idx] and → SELECT.
    - layer_done of non-active engines is ignored.
  - DONE (1 cycle):
    - draw_done = 1; busy ← 0.
    - frame_count += 1 unless the frame ended by timeout.
    - → IDLE.
- Output mux:
  - In DRAW: TXN_INIT, offset_addr and pixel_count come from engine idx, and color = layer_color slice idx.
  - In all other states these outputs are 0.
  - layer_txn_done[i] = TXN_DONE & (state==DRAW) & (i==idx).
- Watchdog:
  - Counts every cycle in DRAW and clears on TXN_DONE.
  - When it reaches TIMEOUT_CYCLES-1: pending ← 0, set the timeout flag, → DONE.
  - timeout_err pulses with draw_done.
- Abort:
  - abort=1 in any state → IDLE next cycle.
  - busy ← 0, layer_draw ← 0, no draw_done, frame_count unchanged.
  - A master burst already in flight completes at the master; a TXN_DONE that arrives in IDLE is dropped.
- Priority: resetn > abort > watchdog > layer_done.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; ff1, ff2, pending, idx, watchdog and frame_count all 0.
- draw rises before edge k → draw_pulse high in cycle k+1 → SELECT in cycle k+2 (busy=1 from k+2) → DRAW and layer_draw in k+3.
- Each layer_done costs one SELECT cycle before the next layer's DRAW.
- The mux outputs are combinational from the registered state/idx; there is no added latency on TXN_INIT/TXN_DONE.
- Empty mask: SELECT at k+2, DONE (draw_done) at k+3.
- layer_done and watchdog expiry in the same cycle: timeout wins.
- TXN_DONE and layer_done in the same cycle: the layer completes normally.

## Test plan
- Full frame:
  - Stimulus: NUM_LAYERS=4, layer_en=4'b1111, each engine model does 2 bursts then done.
  - Required response: layers drawn in order 0,1,2,3; each layer's color on the bus; 8 TXN_DONEs each routed one-hot; one draw_done; frame_count=1.
- Masked frame:
  - Stimulus: layer_en=4'b1010.
  - Required response: only layers 1 and 3 see layer_draw; layer_en changed mid-frame has no effect; then layer_en=0 → draw_done exactly 3 cycles after the draw edge, frame_count +1.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16; engine 2 never receives TXN_DONE.
  - Required response: after 16 cycles in DRAW, draw_done and timeout_err pulse together, layer 3 is not drawn, frame_count unchanged.
- Abort:
  - Stimulus: abort during layer 1.
  - Required response: next cycle IDLE, busy=0, layer_draw=0, TXN_INIT=0, no draw_done; a late TXN_DONE is not forwarded; a new draw then completes normally.
- Re-trigger and hold:
  - Stimulus: draw toggled while busy; draw held high after a frame.
  - Required response: no second frame in either case; only a fresh 0→1 edge starts a frame.
- Reset and wrap:
  - Stimulus: resetn low in mid-DRAW; separately, preload frame_count=0xFFFF and complete a frame.
  - Required response: after reset all outputs are 0; frame_count becomes 0 after the completed frame.
